reg_rename_file: RTL and testbench

//  Architectural register file with ROB-tag renaming; the receiving end of the ROB commit/lookup interface.

---
 rtl/reg_rename_file.sv | 95 +++++++++
 tb/tb_reg_rename_file.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/reg_rename_file.sv
// Architectural register file with ROB-tag renaming, commit retirement and mispredict flush.
// Source lookups resolve to a value or a pending ROB tag using pre-edge state.
module reg_rename_file #(
    parameter int unsigned ROB_W = 4,
    parameter int unsigned XLEN  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic [4:0]       is_rs1,
    input  logic [4:0]       is_rs2,
    output logic             is_rdy1,
    output logic             is_rdy2,
    output logic [XLEN-1:0]  is_val1,
    output logic [XLEN-1:0]  is_val2,
    output logic [ROB_W-1:0] is_tag1,
    output logic [ROB_W-1:0] is_tag2,
    input  logic             is_rename_sgn,
    input  logic [4:0]       is_rd,
    input  logic [ROB_W-1:0] is_rob_name,
    output logic [ROB_W-1:0] rob_ord1,
    output logic [ROB_W-1:0] rob_ord2,
    input  logic             rob_rdy1,
    input  logic             rob_rdy2,
    input  logic [XLEN-1:0]  rob_val1,
    input  logic [XLEN-1:0]  rob_val2,
    input  logic             commit_sgn,
    input  logic [4:0]       commit_dest,
    input  logic [XLEN-1:0]  commit_value,
    input  logic [ROB_W-1:0] commit_rob_name,
    input  logic             jp_wrong
);

    logic [XLEN-1:0]  val_q [32];
    logic [ROB_W-1:0] tag_q [32];
    logic [31:0]      busy_q;

    logic rename_ok;
    logic commit_ok;

    assign rename_ok = is_rename_sgn && (is_rd != 5'd0) && !jp_wrong;
    assign commit_ok = commit_sgn && (commit_dest != 5'd0);

    // Returns {ready, value}; value is zero whenever the operand is still pending.
    function automatic logic [XLEN:0] resolve(input logic [4:0]      rs,
                                              input logic            ord_rdy,
                                              input logic [XLEN-1:0] ord_val);
        if (rs == 5'd0) begin
            return {1'b1, {XLEN{1'b0}}};
        end else if (!busy_q[rs]) begin
            return {1'b1, val_q[rs]};
        end else if (commit_sgn && (commit_dest == rs) && (commit_rob_name == tag_q[rs])) begin
            return {1'b1, commit_value};
        end else if (ord_rdy) begin
            return {1'b1, ord_val};
        end
        return {1'b0, {XLEN{1'b0}}};
    endfunction

    always_comb begin
        {is_rdy1, is_val1} = resolve(is_rs1, rob_rdy1, rob_val1);
        {is_rdy2, is_val2} = resolve(is_rs2, rob_rdy2, rob_val2);
        is_tag1  = tag_q[is_rs1];
        is_tag2  = tag_q[is_rs2];
        rob_ord1 = tag_q[is_rs1];
        rob_ord2 = tag_q[is_rs2];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_q <= '0;
            for (int i = 0; i < 32; i++) begin
                val_q[i] <= '0;
                tag_q[i] <= '0;
            end
        end else if (rdy) begin
            if (jp_wrong) begin
                busy_q <= '0;
            end
            if (commit_ok) begin
                val_q[commit_dest] <= commit_value;
                // Only the rename that the ROB is retiring may release the register.
                if ((tag_q[commit_dest] == commit_rob_name) &&
                    !(rename_ok && (is_rd == commit_dest))) begin
                    busy_q[commit_dest] <= 1'b0;
                end
            end
            if (rename_ok) begin
                busy_q[is_rd] <= 1'b1;
                tag_q[is_rd]  <= is_rob_name;
            end
        end
    end

endmodule

// File: tb/tb_reg_rename_file.sv
// Directed self-checking bench for reg_rename_file.
module tb_reg_rename_file;

    localparam int unsigned ROB_W = 4;
    localparam int unsigned XLEN  = 32;

    logic             clk = 1'b0;
    logic             rst, rdy;
    logic [4:0]       is_rs1, is_rs2, is_rd, commit_dest;
    logic             is_rdy1, is_rdy2, is_rename_sgn, rob_rdy1, rob_rdy2, commit_sgn, jp_wrong;
    logic [XLEN-1:0]  is_val1, is_val2, rob_val1, rob_val2, commit_value;
    logic [ROB_W-1:0] is_tag1, is_tag2, is_rob_name, rob_ord1, rob_ord2, commit_rob_name;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    reg_rename_file #(.ROB_W(ROB_W), .XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .is_rs1(is_rs1), .is_rs2(is_rs2),
        .is_rdy1(is_rdy1), .is_rdy2(is_rdy2),
        .is_val1(is_val1), .is_val2(is_val2),
        .is_tag1(is_tag1), .is_tag2(is_tag2),
        .is_rename_sgn(is_rename_sgn), .is_rd(is_rd), .is_rob_name(is_rob_name),
        .rob_ord1(rob_ord1), .rob_ord2(rob_ord2),
        .rob_rdy1(rob_rdy1), .rob_rdy2(rob_rdy2),
        .rob_val1(rob_val1), .rob_val2(rob_val2),
        .commit_sgn(commit_sgn), .commit_dest(commit_dest),
        .commit_value(commit_value), .commit_rob_name(commit_rob_name),
        .jp_wrong(jp_wrong)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rename(input logic [4:0] rd, input logic [ROB_W-1:0] name);
        is_rename_sgn = 1'b1; is_rd = rd; is_rob_name = name;
    endtask

    task automatic commit(input logic [4:0] rd, input logic [31:0] v, input logic [ROB_W-1:0] name);
        commit_sgn = 1'b1; commit_dest = rd; commit_value = v; commit_rob_name = name;
    endtask

    task automatic idle();
        is_rename_sgn = 1'b0; is_rd = '0; is_rob_name = '0;
        commit_sgn = 1'b0; commit_dest = '0; commit_value = '0; commit_rob_name = '0;
        rob_rdy1 = 1'b0; rob_rdy2 = 1'b0; rob_val1 = '0; rob_val2 = '0; jp_wrong = 1'b0;
    endtask

    initial begin
        rst = 1'b0; rdy = 1'b1; is_rs1 = '0; is_rs2 = '0;
        idle();
        step();
        rst = 1'b1;

        // 1: reset state and a plain commit
        is_rs1 = 5; #1;
        check("rst_rdy1", 32'(is_rdy1), 1);
        check("rst_val1", is_val1, 0);
        check("rst_tag1", 32'(is_tag1), 0);
        check("rst_rdy2_x0", 32'(is_rdy2), 1);
        commit(5, 32'h1234, 0); #1;
        check("commit_pre_edge", is_val1, 0);
        step(); idle(); #1;
        check("commit_val", is_val1, 32'h1234);

        // 2: rename and ROB forwarding
        is_rs1 = 3; rename(3, 7); #1;
        check("rename_same_cycle_rdy", 32'(is_rdy1), 1);
        step(); idle(); #1;
        check("pending_rdy1", 32'(is_rdy1), 0);
        check("pending_tag1", 32'(is_tag1), 7);
        check("pending_ord1", 32'(rob_ord1), 7);
        check("pending_val1", is_val1, 0);
        rob_rdy1 = 1'b1; rob_val1 = 32'hAA; #1;
        check("rob_fwd_rdy1", 32'(is_rdy1), 1);
        check("rob_fwd_val1", is_val1, 32'hAA);
        idle();

        // 3: same-cycle commit bypass on source 2
        is_rs2 = 3; commit(3, 32'h55, 7); #1;
        check("bypass_rdy2", 32'(is_rdy2), 1);
        check("bypass_val2", is_val2, 32'h55);
        check("bypass_ord2", 32'(rob_ord2), 7);
        step(); idle(); #1;
        check("cleared_rdy2", 32'(is_rdy2), 1);
        check("cleared_val2", is_val2, 32'h55);

        // 4: stale commit writes value but leaves newer rename pending
        rename(3, 2); step(); rename(3, 9); step(); idle();
        is_rs1 = 3; commit(3, 32'h66, 2); #1;
        check("stale_no_bypass", 32'(is_rdy1), 0);
        step(); idle(); #1;
        check("stale_busy", 32'(is_rdy1), 0);
        check("stale_tag", 32'(is_tag1), 9);
        jp_wrong = 1'b1; step(); idle(); #1;
        check("stale_val", is_val1, 32'h66);

        // 5: commit and rename of the same register on one edge
        rename(4, 1); step(); idle();
        commit(4, 32'h44, 1); rename(4, 6); step(); idle();
        is_rs2 = 4; #1;
        check("rn_wins_rdy2", 32'(is_rdy2), 0);
        check("rn_wins_tag2", 32'(is_tag2), 6);
        jp_wrong = 1'b1; step(); idle(); #1;
        check("rn_wins_val2", is_val2, 32'h44);

        // 6: flush, x0 and hold
        rename(1, 5); step(); rename(2, 6); step(); idle();
        is_rs1 = 1; is_rs2 = 2; #1;
        check("busy_x1", 32'(is_rdy1), 0);
        check("busy_x2", 32'(is_rdy2), 0);
        jp_wrong = 1'b1; rename(8, 3); step(); idle(); #1;
        check("flush_x1", 32'(is_rdy1), 1);
        check("flush_x2", 32'(is_rdy2), 1);
        check("flush_tag_kept", 32'(is_tag1), 5);
        is_rs1 = 8; #1;
        check("flush_drop_rename", 32'(is_rdy1), 1);
        check("flush_drop_tag", 32'(is_tag1), 0);
        rename(0, 4); commit(0, 32'hDEAD, 0); step(); idle();
        is_rs1 = 0; #1;
        check("x0_rdy", 32'(is_rdy1), 1);
        check("x0_val", is_val1, 0);
        check("x0_tag", 32'(is_tag1), 0);
        rdy = 1'b0; commit(5, 32'h9999, 0); rename(6, 2); step(); idle(); rdy = 1'b1;
        is_rs1 = 5; is_rs2 = 6; #1;
        check("hold_val", is_val1, 32'h1234);
        check("hold_rdy", 32'(is_rdy2), 1);
        check("hold_tag", 32'(is_tag2), 0);

        // reset while rdy is low clears everything
        rename(7, 11); step(); idle();
        is_rs2 = 7; #1;
        check("pre_rst_busy", 32'(is_rdy2), 0);
        rst = 1'b0; rdy = 1'b0; step(); rst = 1'b1; rdy = 1'b1; #1;
        check("mid_rst_rdy", 32'(is_rdy2), 1);
        check("mid_rst_tag", 32'(is_tag2), 0);
        check("mid_rst_val", is_val1, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
